// File: rtl/conv33_ctrl.sv
// Sequencer for one 3x3 convolution engine: loads weights and bias, walks every
// valid 3x3 window of the feature map, and writes each engine result to the output RAM.
module conv33_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int OUT_WIDTH  = 32,
    parameter int IMG_W      = 28,
    parameter int IMG_H      = 28,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [OUT_WIDTH-1:0]    bias_in,
    output logic                    busy,
    output logic                    done,
    output logic                    wt_rd_en,
    output logic [3:0]              wt_rd_addr,
    input  logic [DATA_WIDTH-1:0]   wt_rd_data,
    output logic                    fm_rd_en,
    output logic [ADDR_WIDTH-1:0]   fm_rd_addr,
    input  logic [DATA_WIDTH-1:0]   fm_rd_data,
    output logic [9*DATA_WIDTH-1:0] win_data,
    output logic [9*DATA_WIDTH-1:0] weights,
    output logic [OUT_WIDTH-1:0]    bias,
    output logic                    conv33_en,
    input  logic                    calc_valid,
    input  logic [OUT_WIDTH-1:0]    calc_result,
    output logic                    out_wr_en,
    output logic [ADDR_WIDTH-1:0]   out_wr_addr,
    output logic [OUT_WIDTH-1:0]    out_wr_data
);
    typedef enum logic [2:0] {IDLE, LOAD_W, FETCH, CALC, WAIT, DONE} state_t;

    state_t                          state, state_nx;
    logic [3:0]                      cnt;
    logic [3:0]                      km1;
    logic [ADDR_WIDTH-1:0]           r, c;
    logic [1:0]                      dy, dx;
    logic                            last_win;
    logic [8:0][DATA_WIDTH-1:0]      wts, win;

    assign weights  = wts;
    assign win_data = win;
    assign km1      = cnt - 4'd1;
    assign last_win = (r == ADDR_WIDTH'(IMG_H - 3)) && (c == ADDR_WIDTH'(IMG_W - 3));

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = LOAD_W;
            LOAD_W:  if (cnt == 4'd9) state_nx = FETCH;
            FETCH:   if (cnt == 4'd9) state_nx = CALC;
            CALC:    state_nx = WAIT;
            WAIT:    if (calc_valid) state_nx = last_win ? DONE : FETCH;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Window offset (row, col) of the pixel fetched in FETCH cycle cnt.
    always_comb begin
        case (cnt)
            4'd0:    {dy, dx} = {2'd0, 2'd0};
            4'd1:    {dy, dx} = {2'd0, 2'd1};
            4'd2:    {dy, dx} = {2'd0, 2'd2};
            4'd3:    {dy, dx} = {2'd1, 2'd0};
            4'd4:    {dy, dx} = {2'd1, 2'd1};
            4'd5:    {dy, dx} = {2'd1, 2'd2};
            4'd6:    {dy, dx} = {2'd2, 2'd0};
            4'd7:    {dy, dx} = {2'd2, 2'd1};
            4'd8:    {dy, dx} = {2'd2, 2'd2};
            default: {dy, dx} = {2'd0, 2'd0};
        endcase
    end

    always_comb begin
        busy       = (state != IDLE);
        done       = (state == DONE);
        conv33_en  = (state == CALC);
        wt_rd_en   = (state == LOAD_W) && (cnt < 4'd9);
        wt_rd_addr = wt_rd_en ? cnt : 4'd0;
        fm_rd_en   = (state == FETCH) && (cnt < 4'd9);
        fm_rd_addr = '0;
        if (fm_rd_en)
            fm_rd_addr = (r + ADDR_WIDTH'(dy)) * ADDR_WIDTH'(IMG_W) + c + ADDR_WIDTH'(dx);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt         <= '0;
            r           <= '0;
            c           <= '0;
            wts         <= '0;
            win         <= '0;
            bias        <= '0;
            out_wr_en   <= 1'b0;
            out_wr_addr <= '0;
            out_wr_data <= '0;
        end else begin
            out_wr_en <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (start) begin
                        bias <= bias_in;
                        r    <= '0;
                        c    <= '0;
                    end
                end
                LOAD_W: begin
                    cnt <= (cnt == 4'd9) ? 4'd0 : cnt + 4'd1;
                    if (cnt != 4'd0) wts[km1] <= wt_rd_data;
                end
                FETCH: begin
                    cnt <= (cnt == 4'd9) ? 4'd0 : cnt + 4'd1;
                    if (cnt != 4'd0) win[km1] <= fm_rd_data;
                end
                WAIT: begin
                    if (calc_valid) begin
                        out_wr_en   <= 1'b1;
                        out_wr_data <= calc_result;
                        out_wr_addr <= r * ADDR_WIDTH'(IMG_W - 2) + c;
                        if (c == ADDR_WIDTH'(IMG_W - 3)) begin
                            c <= '0;
                            r <= r + 1'b1;
                        end else begin
                            c <= c + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_conv33_ctrl.sv
// Directed bench for conv33_ctrl on a 4x4 map: RAM and engine models, a table of
// runs with hand-computed results, plus restart and mid-run reset sequences.
module tb_conv33_ctrl;
    localparam int DW = 8;
    localparam int OW = 32;
    localparam int W  = 4;
    localparam int H  = 4;
    localparam int AW = 10;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic [OW-1:0]     bias_in = '0;
    logic              busy, done, wt_rd_en, fm_rd_en, conv33_en, out_wr_en;
    logic [3:0]        wt_rd_addr;
    logic [DW-1:0]     wt_rd_data = '0;
    logic [DW-1:0]     fm_rd_data = '0;
    logic [AW-1:0]     fm_rd_addr, out_wr_addr;
    logic [9*DW-1:0]   win_data, weights;
    logic [OW-1:0]     bias, out_wr_data;
    logic              calc_valid;
    logic [OW-1:0]     calc_result;

    always #5 clk = ~clk;

    conv33_ctrl #(.DATA_WIDTH(DW), .OUT_WIDTH(OW), .IMG_W(W), .IMG_H(H), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .bias_in(bias_in), .busy(busy), .done(done),
        .wt_rd_en(wt_rd_en), .wt_rd_addr(wt_rd_addr), .wt_rd_data(wt_rd_data),
        .fm_rd_en(fm_rd_en), .fm_rd_addr(fm_rd_addr), .fm_rd_data(fm_rd_data),
        .win_data(win_data), .weights(weights), .bias(bias), .conv33_en(conv33_en),
        .calc_valid(calc_valid), .calc_result(calc_result),
        .out_wr_en(out_wr_en), .out_wr_addr(out_wr_addr), .out_wr_data(out_wr_data)
    );

    // Memories with 1-cycle read latency
    logic [DW-1:0] w_mem [9];
    logic [DW-1:0] fm_mem [16];
    always @(posedge clk) begin
        if (wt_rd_en) wt_rd_data <= w_mem[wt_rd_addr];
        if (fm_rd_en) fm_rd_data <= fm_mem[fm_rd_addr[3:0]];
    end

    // Engine: result appears lat cycles after the enable pulse is sampled
    int            lat = 1;
    int            ecnt = 0;
    logic          mvalid = 1'b0;
    logic          inject = 1'b0;
    logic [OW-1:0] mres = '0;
    assign calc_valid  = mvalid | inject;
    assign calc_result = mres;

    function automatic logic [OW-1:0] eng();
        int s = int'($signed(bias));
        for (int k = 0; k < 9; k++)
            s += int'($signed(win_data[k*DW +: DW])) * int'($signed(weights[k*DW +: DW]));
        return OW'(s);
    endfunction

    always @(posedge clk) begin
        mvalid <= 1'b0;
        if (conv33_en) begin
            mres <= eng();
            if (lat <= 1) mvalid <= 1'b1;
            else          ecnt   <= lat - 1;
        end else if (ecnt > 0) begin
            ecnt <= ecnt - 1;
            if (ecnt == 1) mvalid <= 1'b1;
        end
    end

    // Monitors
    typedef struct { int addr; int data; } wr_t;
    wr_t wq[$];
    int  rdq[$];
    int  ndone = 0;
    always @(negedge clk) begin
        if (out_wr_en) wq.push_back('{int'(out_wr_addr), int'($signed(out_wr_data))});
        if (fm_rd_en)  rdq.push_back(int'(fm_rd_addr));
        if (done)      ndone++;
    end

    int nassert = 0;
    int nfail   = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        nassert++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chkv(input string nm, input logic [127:0] act, input logic [127:0] exp);
        nassert++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    typedef struct packed {
        int pat;        // 0: all pixels 1, 1: pixel[a]=a
        int wpat;       // 0: all weights 1, 1: w[k]=k-4
        int bv;
        int lat;
        int inj_n;      // cycle of a stray calc_valid pulse (0 = none)
        int restart_n;  // cycle of a start re-pulse while busy (0 = none)
        int cycles;     // expected busy cycles == cycle index of done
        logic [3:0][31:0] exp;
    } vec_t;

    function automatic vec_t mk(int p, int wp, int b, int l, int inj, int rs, int cy,
                                int e0, int e1, int e2, int e3);
        vec_t v;
        v.pat = p; v.wpat = wp; v.bv = b; v.lat = l; v.inj_n = inj; v.restart_n = rs;
        v.cycles = cy;
        v.exp[0] = e0; v.exp[1] = e1; v.exp[2] = e2; v.exp[3] = e3;
        return v;
    endfunction

    task automatic load_mem(input int pat, input int wpat);
        for (int a = 0; a < 16; a++) fm_mem[a] = (pat == 1) ? DW'(a) : DW'(1);
        for (int k = 0; k < 9; k++)  w_mem[k]  = (wpat == 1) ? DW'(k - 4) : DW'(1);
    endtask

    task automatic chk_idle_zero(input string tag);
        chk({tag, "_ctl"}, {busy, done, wt_rd_en, fm_rd_en, conv33_en, out_wr_en}, 0);
        chk({tag, "_addr"}, {wt_rd_addr, fm_rd_addr, out_wr_addr}, 0);
        chk({tag, "_wdata"}, out_wr_data, 0);
        chkv({tag, "_win_wt"}, {win_data, weights[55:0]}, 0);
        chk({tag, "_bias"}, bias, 0);
    endtask

    task automatic run(input vec_t v, input string tag);
        int n, done_at, nen, stray;
        bit waitf;
        logic [8:0][DW-1:0] ew, ewin;
        int ra0 [9] = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
        int ra3 [9] = '{5, 6, 7, 9, 10, 11, 13, 14, 15};
        load_mem(v.pat, v.wpat);
        for (int k = 0; k < 9; k++) ew[k] = w_mem[k];
        lat = v.lat;
        wq.delete(); rdq.delete(); ndone = 0;
        done_at = -1; nen = 0; stray = 0; waitf = 0;
        @(negedge clk); start = 1'b1; bias_in = OW'(v.bv);
        @(negedge clk); start = 1'b0;
        for (n = 1; n < 3000; n++) begin
            if (!busy) break;
            if (done) done_at = n;
            if (waitf && (fm_rd_en || wt_rd_en)) stray++;
            if (conv33_en) begin
                chk({tag, "_calc_bias"}, longint'($signed(bias)), v.bv);
                chkv({tag, "_calc_weights"}, weights, ew);
                if (nen < 4) begin
                    for (int k = 0; k < 9; k++)
                        ewin[k] = fm_mem[((nen / 2) + k / 3) * W + (nen % 2) + k % 3];
                    chkv({tag, "_win"}, win_data, ewin);
                end
                nen++;
                waitf = 1;
            end else if (waitf && calc_valid) begin
                waitf = 0;
            end
            inject = (n == v.inj_n);
            start  = (n == v.restart_n);
            @(negedge clk);
        end
        inject = 1'b0; start = 1'b0;
        chk({tag, "_busy_cycles"}, n - 1, v.cycles);
        chk({tag, "_done_at"}, done_at, v.cycles);
        chk({tag, "_done_cnt"}, ndone, 1);
        chk({tag, "_windows"}, nen, 4);
        chk({tag, "_stray_rd"}, stray, 0);
        chk({tag, "_nwrites"}, wq.size(), 4);
        for (int i = 0; i < 4 && i < wq.size(); i++) begin
            chk({tag, "_wr_addr"}, wq[i].addr, i);
            chk({tag, "_wr_data"}, wq[i].data, longint'($signed(v.exp[i])));
        end
        chk({tag, "_nreads"}, rdq.size(), 36);
        if (rdq.size() >= 36) begin
            for (int k = 0; k < 9; k++) begin
                chk({tag, "_rd_w0"}, rdq[k], ra0[k]);
                chk({tag, "_rd_w3"}, rdq[27 + k], ra3[k]);
            end
        end
        chkv({tag, "_wt_persist"}, weights, ew);
        chk({tag, "_bias_persist"}, longint'($signed(bias)), v.bv);
    endtask

    vec_t tv [5];

    initial begin
        int n0;
        tv[0] = mk(0, 0,   0, 1,  0,  0, 59,   9,   9,   9,   9);
        tv[1] = mk(1, 0,   0, 1,  0, 15, 59,  45,  54,  81,  90);
        tv[2] = mk(1, 1,  -7, 1,  0,  0, 59,  71,  71,  71,  71);
        tv[3] = mk(0, 1,   5, 5, 30,  0, 75,   5,   5,   5,   5);
        tv[4] = mk(1, 0, 100, 3,  0,  0, 67, 145, 154, 181, 190);

        repeat (3) @(negedge clk);
        chk_idle_zero("reset");
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 5; i++) run(tv[i], $sformatf("t%0d", i));

        // Reset during FETCH of window 2: abort with no done and no further writes
        load_mem(0, 1);
        lat = 1; wq.delete(); ndone = 0;
        @(negedge clk); start = 1'b1; bias_in = 32'd3;
        @(negedge clk); start = 1'b0;
        n0 = 1;
        while (n0 < 37) begin @(negedge clk); n0++; end
        chk("abort_fm_rd_en", fm_rd_en, 1);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        chk_idle_zero("abort");
        repeat (100) @(negedge clk);
        chk("abort_busy", busy, 0);
        chk("abort_done_cnt", ndone, 0);
        chk("abort_nwrites", wq.size(), 2);

        run(tv[0], "after_abort");

        $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
        $finish;
    end
endmodule

// File: doc/conv33_ctrl.md
Name: conv33_ctrl

Overview:
- Sequencer for a single 3x3 convolution engine over one feature map: stride 1, no padding, one input channel.
- Loads 9 weights from a weight RAM and latches a bias, then walks every 3x3 window of an input feature-map RAM.
- For each window it presents the 9 pixels plus weights and bias to the engine, pulses its enable, waits for the engine's valid, and writes the result to an output RAM.
- Sits between the feature/weight memories and the conv engine; one instance per engine.

Parameters:
DATA_WIDTH, 8, pixel/weight width (signed)
OUT_WIDTH, 32, engine result and bias width (signed)
IMG_W, 28, input map width, >=3
IMG_H, 28, input map height, >=3
ADDR_WIDTH, 10, feature-map and output RAM address width

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-low (0 = reset)
start  in  1  begin a run; sampled only in IDLE
bias_in  in  OUT_WIDTH  bias, latched when start is accepted
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse at end of run
wt_rd_en  out  1  weight RAM read strobe
wt_rd_addr  out  4  weight index 0..8
wt_rd_data  in  DATA_WIDTH  valid 1 cycle after wt_rd_en
fm_rd_en  out  1  feature RAM read strobe
fm_rd_addr  out  ADDR_WIDTH  row*IMG_W+col
fm_rd_data  in  DATA_WIDTH  valid 1 cycle after fm_rd_en
win_data  out  9*DATA_WIDTH  window; slice k = pixel (k/3,k%3), k=0 in LSBs
weights  out  9*DATA_WIDTH  slice k = weight k
bias  out  OUT_WIDTH  latched bias
conv33_en  out  1  engine enable, one-cycle pulse per window
calc_valid  in  1  engine result valid
calc_result  in  OUT_WIDTH  engine result
out_wr_en  out  1  output RAM write strobe
out_wr_addr  out  ADDR_WIDTH  r*(IMG_W-2)+c
out_wr_data  out  OUT_WIDTH  result

Behaviour:
- Reset (rst=0 at a clock edge):
  - State goes to IDLE; row/col counters cleared.
  - All outputs, win_data, weights and bias go to 0.
  - Any pending write is dropped. Reset mid-run aborts without a done pulse.
- States: IDLE, LOAD_W, FETCH, CALC, WAIT, DONE.
- IDLE:
  - start=1 latches bias_in, clears r,c and goes to LOAD_W.
  - start in any other state is ignored.
- LOAD_W: 10 cycles.
  - Cycles 0..8: wt_rd_en=1, wt_rd_addr=0..8.
  - Cycles 1..9: capture wt_rd_data into weights slice (cycle-1).
  - Then go to FETCH.
- FETCH: 10 cycles for window (r,c).
  - Cycles 0..8: fm_rd_en=1, fm_rd_addr=(r+k/3)*IMG_W+(c+k%3) for k=0..8.
  - Capture into win_data slice k one cycle later.
  - Then go to CALC.
- CALC: conv33_en=1 for exactly one cycle; go to WAIT.
  - win_data, weights and bias are held stable from CALC until calc_valid is seen.
- WAIT: hold until calc_valid=1 (no timeout).
  - On that edge: register out_wr_en=1, out_wr_data=calc_result, out_wr_addr=r*(IMG_W-2)+c. The write pulse is 1 cycle.
  - Advance the counters: c+1; if c==IMG_W-3 then c=0, r+1.
  - If the window was (IMG_H-3, IMG_W-3), go to DONE; else go to FETCH.
  - The write pulse overlaps FETCH cycle 0 of the next window, or the DONE cycle.
- DONE: done=1 for one cycle; go to IDLE. busy falls in the same cycle IDLE is entered.
- calc_valid outside WAIT is ignored and produces no write.
- Exactly one write per window; (IMG_W-2)*(IMG_H-2) writes per run, in row-major order.
- Read strobes are never asserted outside LOAD_W/FETCH.
- Addresses are computed in ADDR_WIDTH, unsigned. Overflow is a parameterisation error; no check in RTL.
- Throughput with a 1-cycle engine is 12 cycles/window. Total run = 10 + 12*N + 1 cycles, N = window count.
- weights and bias persist after DONE until the next accepted start.

Test Plan:
- IMG_W=IMG_H=4, all pixels=1, weights=1, bias_in=0, engine model with 1-cycle latency:
  - 4 writes, data=9, addr 0,1,2,3.
  - done high in the cycle after edge 59, counting from the start edge.
- IMG_W=IMG_H=4, pixel[a]=a: window (0,0) read addresses are 0,1,2,4,5,6,8,9,10 in order.
  - Window (1,1) read addresses are 5,6,7,9,10,11,13,14,15.
  - win_data slices match these addresses.
- Weight RAM holds w[k]=k-4, bias_in=-7:
  - weights slices read -4..4 after LOAD_W.
  - bias=-7 during every CALC cycle.
- Engine model delays calc_valid by 5 cycles:
  - WAIT holds for 5 cycles; no new reads are issued.
  - Exactly one out_wr_en per window; an extra calc_valid pulse injected in FETCH causes no write.
- start re-pulsed while busy: ignored, run completes normally.
  - Then rst=0 for 1 cycle during FETCH of window 2: all outputs 0, state IDLE, no done, no further writes.
  - A new start then runs cleanly from window 0.
